// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the sequenced ALU controller: op codes, FSM states and
// register-file geometry.
package alu_ctrl_pkg;

    localparam int unsigned REG_AW   = 2;
    localparam int unsigned NUM_REGS = 1 << REG_AW;

    localparam logic [2:0] OP_MOV = 3'b000;
    localparam logic [2:0] OP_NOT = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_AND = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_EX   = 2'd2,
        S_WB   = 2'd3
    } state_e;

    function automatic logic op_is_illegal(input logic [2:0] op);
        return op > OP_AND;
    endfunction

    function automatic logic op_writes_carry(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/param_ALU.sv
// N-bit combinational ALU: MOV/NOT/ADD/SUB/OR/AND on R2 (A) and R3 (B).
// SUB forces its own carry-in, so it computes R2 + ~R3 + 1.
module param_ALU
    import alu_ctrl_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic [2:0]   op,
    input  logic [N-1:0] R2,
    input  logic [N-1:0] R3,
    input  logic         c_in,
    output logic [N-1:0] R1,
    output logic         c_out
);

    logic [N-1:0] b_eff;
    logic         c_eff;
    logic [N:0]   sum;

    always_comb begin
        b_eff = (op == OP_SUB) ? ~R3 : R3;
        c_eff = (op == OP_SUB) ? 1'b1 : ((op == OP_ADD) ? c_in : 1'b0);
        sum   = {1'b0, R2} + {1'b0, b_eff} + {{N{1'b0}}, c_eff};
    end

    always_comb begin
        R1    = '0;
        c_out = 1'b0;
        case (op)
            OP_MOV: R1 = R2;
            OP_NOT: R1 = ~R2;
            OP_ADD, OP_SUB: begin
                R1    = sum[N-1:0];
                c_out = sum[N];
            end
            OP_OR:  R1 = R2 | R3;
            OP_AND: R1 = R2 & R3;
            default: R1 = '0;
        endcase
    end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Multi-cycle controller: accepts one register-to-register instruction at a
// time and walks it through read, execute and writeback around param_ALU.
module alu_seq_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [2:0]        instr_op,
    input  logic [REG_AW-1:0] instr_rd,
    input  logic [REG_AW-1:0] instr_rs,
    input  logic [REG_AW-1:0] instr_rt,
    input  logic              instr_use_c,
    input  logic              ld_en,
    input  logic [REG_AW-1:0] ld_addr,
    input  logic [N-1:0]      ld_data,
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [N-1:0]      dbg_data,
    output logic              done,
    output logic              illegal,
    output logic [N-1:0]      result,
    output logic              flag_c,
    output logic              flag_z
);

    state_e state_q, state_d;

    logic [N-1:0]      regs_q [NUM_REGS];
    logic [2:0]        op_q;
    logic [REG_AW-1:0] rd_q, rs_q, rt_q;
    logic              use_c_q;
    logic [N-1:0]      a_q, b_q;
    logic              cin_q;
    logic [N-1:0]      ex_res_q;
    logic              ex_c_q;
    logic [N-1:0]      result_q;
    logic              flag_c_q, flag_z_q;

    logic [N-1:0]      alu_res;
    logic              alu_c;
    logic              accept;

    param_ALU #(.N(N)) u_alu (
        .op    (op_q),
        .R2    (a_q),
        .R3    (b_q),
        .c_in  (cin_q),
        .R1    (alu_res),
        .c_out (alu_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        instr_ready = 1'b0;
        done        = 1'b0;
        illegal     = 1'b0;
        accept      = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                // A pending load blocks acceptance so the two never share an edge.
                instr_ready = !ld_en;
                accept      = instr_valid && !ld_en;
                if (accept) begin
                    state_d = S_RD;
                end
            end
            S_RD: state_d = S_EX;
            S_EX: state_d = S_WB;
            S_WB: begin
                done    = 1'b1;
                illegal = op_is_illegal(op_q);
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            op_q     <= OP_MOV;
            rd_q     <= '0;
            rs_q     <= '0;
            rt_q     <= '0;
            use_c_q  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            cin_q    <= 1'b0;
            ex_res_q <= '0;
            ex_c_q   <= 1'b0;
            result_q <= '0;
            flag_c_q <= 1'b0;
            flag_z_q <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (ld_en) begin
                        regs_q[ld_addr] <= ld_data;
                    end else if (accept) begin
                        op_q    <= instr_op;
                        rd_q    <= instr_rd;
                        rs_q    <= instr_rs;
                        rt_q    <= instr_rt;
                        use_c_q <= instr_use_c;
                    end
                end
                // Operands are snapshotted here, so rd may alias rs/rt safely.
                S_RD: begin
                    a_q   <= regs_q[rs_q];
                    b_q   <= regs_q[rt_q];
                    cin_q <= use_c_q ? flag_c_q : 1'b0;
                end
                S_EX: begin
                    ex_res_q <= alu_res;
                    ex_c_q   <= alu_c;
                end
                S_WB: begin
                    if (!op_is_illegal(op_q)) begin
                        regs_q[rd_q] <= ex_res_q;
                        result_q     <= ex_res_q;
                        flag_z_q     <= (ex_res_q == '0);
                        if (op_writes_carry(op_q)) begin
                            flag_c_q <= ex_c_q;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign dbg_data = regs_q[dbg_addr];
    assign result   = result_q;
    assign flag_c   = flag_c_q;
    assign flag_z   = flag_z_q;

endmodule
